fwd_hazard_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the 5-stage pipelined datapath. It tracks the destination-register metadata of the instructions in EX, MEM and WB in its own shadow pipeline. From that state it drives the select lines of the two 32-bit 3-to-1 ALU-operand muxes, and it issues stall and bubble control to the IF/ID and ID/EX registers. It sits beside the ID/EX boundary and owns no datapath values, only register numbers and control bits.

---
 rtl/fwd_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for a 5-stage pipeline.
// Holds only register numbers and control bits for EX/MEM/WB, never datapath values.

module fwd_sel #(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic [REG_W-1:0] src,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_rw,
  input  logic             mem_mr,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_rw,
  output logic [1:0]       sel
);
  // MEM wins over WB so the youngest producer is chosen; a load in MEM has no result yet
  always_comb begin
    sel = 2'b00;
    if (ex_valid && mem_valid && mem_rw && !mem_mr && (mem_dest != '0) && (mem_dest == src))
      sel = 2'b10;
    else if (ex_valid && wb_valid && wb_rw && (wb_dest != '0) && (wb_dest == src))
      sel = 2'b01;
  end
endmodule

module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             IdValid,
  input  logic [REG_W-1:0] IdRs,
  input  logic [REG_W-1:0] IdRt,
  input  logic [REG_W-1:0] IdDest,
  input  logic             IdRegWrite,
  input  logic             IdMemRead,
  input  logic             Flush,
  output logic [1:0]       SelA,
  output logic [1:0]       SelB,
  output logic             Stall,
  output logic [CNT_W-1:0] StallCount
);
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic             rw;
    logic             mr;
  } ex_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             rw;
    logic             mr;
  } mem_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             rw;
  } wb_t;

  ex_t              ex_q, ex_d;
  mem_t             mem_q, mem_d;
  wb_t              wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign Stall = IdValid && !Flush && ex_q.valid && ex_q.mr && ex_q.rw &&
                 (ex_q.dest != '0) && ((ex_q.dest == IdRs) || (ex_q.dest == IdRt));

  always_comb begin
    ex_d = '0;
    if (IdValid && !Stall && !Flush)
      ex_d = '{valid: 1'b1, rs: IdRs, rt: IdRt, dest: IdDest, rw: IdRegWrite, mr: IdMemRead};
    mem_d = '{valid: ex_q.valid, dest: ex_q.dest, rw: ex_q.rw, mr: ex_q.mr};
    wb_d  = '{valid: mem_q.valid, dest: mem_q.dest, rw: mem_q.rw};
    cnt_d = cnt_q;
    if (Stall && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  // operand 0 = A (rs), operand 1 = B (rt)
  logic [1:0][REG_W-1:0] ex_src;
  logic [1:0][1:0]       sel;
  assign ex_src = {ex_q.rt, ex_q.rs};

  for (genvar g = 0; g < 2; g++) begin : g_op
    fwd_sel #(.REG_W(REG_W)) u_sel (
      .ex_valid (ex_q.valid),
      .src      (ex_src[g]),
      .mem_valid(mem_q.valid),
      .mem_dest (mem_q.dest),
      .mem_rw   (mem_q.rw),
      .mem_mr   (mem_q.mr),
      .wb_valid (wb_q.valid),
      .wb_dest  (wb_q.dest),
      .wb_rw    (wb_q.rw),
      .sel      (sel[g])
    );
  end

  assign SelA       = sel[0];
  assign SelB       = sel[1];
  assign StallCount = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; a narrow-counter twin checks saturation cheaply.

module tb_fwd_hazard_ctrl;
  logic        Clk, Rst, IdValid, IdRegWrite, IdMemRead, Flush;
  logic [4:0]  IdRs, IdRt, IdDest;
  logic [1:0]  SelA, SelB, SelA4, SelB4;
  logic        Stall, Stall4;
  logic [15:0] StallCount;
  logic [3:0]  StallCount4;
  int          n_chk, n_pass;

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt), .IdDest(IdDest),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .Flush(Flush),
    .SelA(SelA), .SelB(SelB), .Stall(Stall), .StallCount(StallCount)
  );

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt), .IdDest(IdDest),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .Flush(Flush),
    .SelA(SelA4), .SelB(SelB4), .Stall(Stall4), .StallCount(StallCount4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // drive ID inputs just after an edge, then let comb outputs settle
  task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] dst, input logic rw, input logic mr, input logic fl);
    IdValid = v; IdRs = rs; IdRt = rt; IdDest = dst; IdRegWrite = rw; IdMemRead = mr; Flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic nop();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    Rst = 1'b1;
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    Rst = 1'b0;

    // reset state, with ID presenting a reader
    id(1'b1, 5'd10, 5'd10, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("rst_selA", 32'(SelA), 32'd0);
    chk("rst_selB", 32'(SelB), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_cnt", 32'(StallCount), 32'd0);
    tick();
    drain();

    // ALU producer -> next instruction: MEM forward
    id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0); tick();
    id(1'b1, 5'd8, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0);
    chk("d1_stall", 32'(Stall), 32'd0);
    tick();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("d1_selA", 32'(SelA), 32'd2);
    chk("d1_selB", 32'(SelB), 32'd0);
    chk("d1_stall2", 32'(Stall), 32'd0);
    tick();
    drain();

    // distance 2 -> WB forward, distance 3 -> none
    id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0); tick();
    nop();
    id(1'b1, 5'd4, 5'd8, 5'd12, 1'b1, 1'b0, 1'b0); tick();
    id(1'b1, 5'd5, 5'd8, 5'd13, 1'b1, 1'b0, 1'b0);
    chk("d2_selB", 32'(SelB), 32'd1);
    chk("d2_selA", 32'(SelA), 32'd0);
    tick();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("d3_selB", 32'(SelB), 32'd0);
    chk("d3_selA", 32'(SelA), 32'd0);
    tick();
    drain();

    // two producers of $9: MEM beats WB
    id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0); tick();
    id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0); tick();
    id(1'b1, 5'd9, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0); tick();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("prio_selA", 32'(SelA), 32'd2);
    chk("prio_selB", 32'(SelB), 32'd0);
    tick();
    drain();

    // load-use: one stall, then WB forward on both operands
    id(1'b1, 5'd1, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0);
    chk("lu_nostall", 32'(Stall), 32'd0);
    tick();
    id(1'b1, 5'd10, 5'd10, 5'd14, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", 32'(Stall), 32'd1);
    chk("lu_cnt0", 32'(StallCount), 32'd0);
    tick();
    chk("lu_stall_t1", 32'(Stall), 32'd0);
    chk("lu_cnt1", 32'(StallCount), 32'd1);
    chk("lu_selA_t1", 32'(SelA), 32'd0);
    tick();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_selA", 32'(SelA), 32'd1);
    chk("lu_selB", 32'(SelB), 32'd1);
    tick();
    drain();

    // dest $0 never forwards
    id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0); tick();
    id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("r0_selA", 32'(SelA), 32'd0);
    chk("r0_selB", 32'(SelB), 32'd0);
    tick();
    drain();

    // flush overrides stall; squashed add (dest $14) never forwards
    id(1'b1, 5'd1, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0); tick();
    id(1'b1, 5'd10, 5'd10, 5'd14, 1'b1, 1'b0, 1'b1);
    chk("fl_stall", 32'(Stall), 32'd0);
    tick();
    id(1'b1, 5'd14, 5'd10, 5'd16, 1'b1, 1'b0, 1'b0);
    chk("fl_stall2", 32'(Stall), 32'd0);
    tick();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("fl_selA", 32'(SelA), 32'd0);
    chk("fl_selB", 32'(SelB), 32'd1);
    chk("fl_cnt", 32'(StallCount), 32'd1);
    tick();
    drain();

    // reset with a load in MEM and its consumer waiting in ID
    id(1'b1, 5'd1, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0); tick();
    id(1'b1, 5'd10, 5'd10, 5'd14, 1'b1, 1'b0, 1'b0); tick();
    chk("mr_cnt_pre", 32'(StallCount), 32'd2);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    id(1'b1, 5'd10, 5'd10, 5'd14, 1'b1, 1'b0, 1'b0);
    chk("mr_selA", 32'(SelA), 32'd0);
    chk("mr_selB", 32'(SelB), 32'd0);
    chk("mr_stall", 32'(Stall), 32'd0);
    chk("mr_cnt", 32'(StallCount), 32'd0);
    chk("mr_cnt4", 32'(StallCount4), 32'd0);
    tick();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("mr_first_selA", 32'(SelA), 32'd0);
    chk("mr_first_selB", 32'(SelB), 32'd0);
    tick();
    drain();

    // 2^4+3 stalls: narrow counter saturates at 0xF, wide one keeps counting
    for (int i = 0; i < 19; i++) begin
      id(1'b1, 5'd1, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0); tick();
      id(1'b1, 5'd10, 5'd2, 5'd14, 1'b1, 1'b0, 1'b0);
      chk($sformatf("sat_stall%0d", i), 32'(Stall4), 32'd1);
      tick();
      chk($sformatf("sat_cnt4_%0d", i), 32'(StallCount4), (i < 15) ? 32'(i + 1) : 32'd15);
    end
    chk("sat_cnt16", 32'(StallCount), 32'd19);
    drain();
    chk("sat_hold4", 32'(StallCount4), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
